// File: rtl/am_mag_sqrt_ctrl.sv
// Envelope magnitude engine: squares a signed I/Q pair, then runs a non-restoring integer sqrt one bit per clock.
// Define SQRT_ROUND_EN to round the result to nearest (adds one cycle before DONE); default is floor.
//
// state  | meaning
// IDLE   | waiting for an I/Q pair, in_ready high
// SQUARE | a <= i*i + q*q, clear root/remainder/count
// ITER   | one root bit per cycle, IN_W cycles
// RND    | remainder correction and round-to-nearest (SQRT_ROUND_EN only)
// DONE   | result presented, held until out_ready
module am_mag_sqrt_ctrl #(
  parameter int IN_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] i_in,
  input  logic [IN_W-1:0] q_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IN_W-1:0] mag_out,
  output logic            busy
);

  localparam int RW = IN_W + 2;
  localparam int CW = $clog2(IN_W);
  localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

  typedef enum logic [2:0] {IDLE, SQUARE, ITER, RND, DONE} state_t;

  state_t state, state_nxt;

  logic signed [IN_W-1:0]   i_r, q_r;
  logic signed [2*IN_W-1:0] i_sq, q_sq;
  logic [2*IN_W-1:0]        a;
  logic [IN_W-1:0]          q_acc, q_step;
  logic [RW-1:0]            r, r_step, right, left;
  logic [CW-1:0]            count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = SQUARE;
      end
      SQUARE: state_nxt = ITER;
      ITER: begin
`ifdef SQRT_ROUND_EN
        if (count == LAST) state_nxt = RND;
`else
        if (count == LAST) state_nxt = DONE;
`endif
      end
      RND: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Products are formed at 2*IN_W bits so the most negative sample squares correctly.
  always_comb begin
    i_sq   = i_r * i_r;
    q_sq   = q_r * q_r;
    right  = {q_acc, r[RW-1], 1'b1};
    left   = {r[IN_W-1:0], a[2*IN_W-1 -: 2]};
    r_step = r[RW-1] ? (left + right) : (left - right);
    q_step = {q_acc[IN_W-2:0], ~r_step[RW-1]};
  end

`ifdef SQRT_ROUND_EN
  logic [RW-1:0]   r_fix;
  logic [IN_W-1:0] q_rnd;

  // A corrected remainder above q means sqrt(P) >= q + 0.5.
  always_comb begin
    r_fix = r[RW-1] ? (r + {1'b0, q_acc, 1'b1}) : r;
    q_rnd = q_acc;
    if ((r_fix > {2'b00, q_acc}) && (q_acc != {IN_W{1'b1}})) q_rnd = q_acc + 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_r     <= '0;
      q_r     <= '0;
      a       <= '0;
      q_acc   <= '0;
      r       <= '0;
      count   <= '0;
      mag_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            i_r <= i_in;
            q_r <= q_in;
          end
        end
        SQUARE: begin
          a     <= $unsigned(i_sq) + $unsigned(q_sq);
          q_acc <= '0;
          r     <= '0;
          count <= '0;
        end
        ITER: begin
          a     <= {a[2*IN_W-3:0], 2'b00};
          r     <= r_step;
          q_acc <= q_step;
          count <= count + 1'b1;
`ifndef SQRT_ROUND_EN
          if (count == LAST) mag_out <= q_step;
`endif
        end
        RND: begin
`ifdef SQRT_ROUND_EN
          mag_out <= q_rnd;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_am_mag_sqrt_ctrl.sv
// Self-checking bench for am_mag_sqrt_ctrl: scoreboard of reference magnitudes, latency, backpressure and reset cases.
// Honours SQRT_ROUND_EN in its reference model and timing expectations.
module tb_am_mag_sqrt_ctrl;

  localparam int IN_W = 16;
`ifdef SQRT_ROUND_EN
  localparam int LAT_EDGE = IN_W + 3;
  localparam int PERIOD   = IN_W + 4;
`else
  localparam int LAT_EDGE = IN_W + 2;
  localparam int PERIOD   = IN_W + 3;
`endif

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] i_in;
  logic [IN_W-1:0] q_in;
  logic            out_valid;
  logic            out_ready;
  logic [IN_W-1:0] mag_out;
  logic            busy;

  int compared   = 0;
  int mismatched = 0;
  logic [IN_W-1:0] sb[$];

  am_mag_sqrt_ctrl #(.IN_W(IN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i_in      (i_in),
    .q_in      (q_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag_out   (mag_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-greedy integer sqrt, independent of the DUT's non-restoring recurrence.
  function automatic logic [IN_W-1:0] ref_mag(input logic signed [IN_W-1:0] iv, input logic signed [IN_W-1:0] qv);
    longint p, s, t;
    p = longint'(iv) * longint'(iv) + longint'(qv) * longint'(qv);
    s = 0;
    for (int b = IN_W - 1; b >= 0; b--) begin
      t = s | (longint'(1) << b);
      if (t * t <= p) s = t;
    end
`ifdef SQRT_ROUND_EN
    if ((p - s * s > s) && (s < (longint'(1) << IN_W) - 1)) s = s + 1;
`endif
    return s[IN_W-1:0];
  endfunction

  // One full operation; starts and ends on a falling edge.
  task automatic run_op(input logic signed [IN_W-1:0] iv, input logic signed [IN_W-1:0] qv,
                        input int hold, input bit check_lat);
    int edges;
    logic [IN_W-1:0] exp_v;
    edges = 0;
    while (!in_ready && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    compared++;
    if (!in_ready) begin
      mismatched++;
      $display("FAIL in_ready_wait: in_ready=%0b after %0d cycles, required 1", in_ready, edges);
      return;
    end
    in_valid = 1'b1;
    i_in = iv;
    q_in = qv;
    sb.push_back(ref_mag(iv, qv));
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    exp_v = sb.pop_front();
    compared++;
    if (!out_valid) begin
      mismatched++;
      $display("FAIL out_valid_timeout: I=%0d Q=%0d no out_valid after %0d edges", iv, qv, edges);
      return;
    end
    if (check_lat) begin
      compared++;
      if (edges + 1 !== LAT_EDGE) begin
        mismatched++;
        $display("FAIL latency: I=%0d Q=%0d output edge accept+%0d, required accept+%0d", iv, qv, edges + 1, LAT_EDGE);
      end
    end
    for (int k = 0; k < hold; k++) begin
      compared++;
      if (out_valid !== 1'b1 || mag_out !== exp_v || in_ready !== 1'b0 || busy !== 1'b1) begin
        mismatched++;
        $display("FAIL hold_stable: cyc %0d valid=%0b mag=%0d in_ready=%0b busy=%0b, required 1/%0d/0/1",
                 k, out_valid, mag_out, in_ready, busy, exp_v);
      end
      @(negedge clk);
    end
    compared++;
    if (mag_out !== exp_v) begin
      mismatched++;
      $display("FAIL mag: I=%0d Q=%0d mag_out=%0d, required %0d", iv, qv, mag_out, exp_v);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL after_handshake: out_valid=%0b in_ready=%0b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    i_in = '0;
    q_in = '0;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: %0b, required 1", in_ready); end
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: %0b, required 0", out_valid); end
    compared++;
    if (mag_out !== '0) begin mismatched++; $display("FAIL reset_mag_out: %0d, required 0", mag_out); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: %0b, required 0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(16'sd3, 16'sd4, 0, 1'b1);
    run_op(16'sd0, 16'sd0, 0, 1'b1);
    run_op(-16'sd1, 16'sd0, 0, 1'b0);
    run_op(16'sd11, 16'sd1, 0, 1'b0);
    run_op(-16'sd32768, -16'sd32768, 0, 1'b1);
    run_op(16'sd32767, -16'sd32768, 1, 1'b0);
  endtask

  // Result held 20 cycles while the next pair waits with in_valid high.
  task automatic test_backpressure();
    logic [IN_W-1:0] exp_v;
    int edges;
    in_valid = 1'b1;
    i_in = 16'sd300;
    q_in = -16'sd400;
    exp_v = ref_mag(16'sd300, -16'sd400);
    @(posedge clk);
    @(negedge clk);
    i_in = 16'sd12;
    q_in = 16'sd5;
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    for (int k = 0; k < 20; k++) begin
      compared++;
      if (out_valid !== 1'b1 || mag_out !== exp_v || in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL backpressure: cyc %0d valid=%0b mag=%0d in_ready=%0b, required 1/%0d/0",
                 k, out_valid, mag_out, in_ready, exp_v);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    compared++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_release: busy=%0b in_ready=%0b out_valid=%0b, required 0/1/0", busy, in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    sb.push_back(ref_mag(16'sd12, 16'sd5));
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL bp_second_accept: busy=%0b, required 1", busy); end
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    exp_v = sb.pop_front();
    compared++;
    if (mag_out !== exp_v || out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_second_mag: mag=%0d valid=%0b, required %0d/1", mag_out, out_valid, exp_v);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    i_in = 16'sd1000;
    q_in = 16'sd2000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || mag_out !== '0) begin
      mismatched++;
      $display("FAIL mid_reset: valid=%0b busy=%0b in_ready=%0b mag=%0d, required 0/0/1/0",
               out_valid, busy, in_ready, mag_out);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL mid_reset_no_pulse: cyc %0d out_valid=%0b, required 0", k, out_valid);
      end
      @(negedge clk);
    end
    run_op(16'sd6, 16'sd8, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic signed [IN_W-1:0] pi[3];
    logic signed [IN_W-1:0] pq[3];
    int t_acc[3];
    int n_acc, n_out;
    bit acc_now;
    logic [IN_W-1:0] exp_v;
    pi[0] = 16'sd100;   pq[0] = -16'sd200;
    pi[1] = -16'sd5;    pq[1] = 16'sd7;
    pi[2] = 16'sd1234;  pq[2] = -16'sd4321;
    n_acc = 0;
    n_out = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    i_in = pi[0];
    q_in = pq[0];
    for (int c = 0; c < 150 && n_out < 3; c++) begin
      acc_now = 1'b0;
      if (out_valid) begin
        n_out++;
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL b2b_unexpected: mag=%0d with empty scoreboard", mag_out);
        end else begin
          exp_v = sb.pop_front();
          if (mag_out !== exp_v) begin
            mismatched++;
            $display("FAIL b2b_mag: mag=%0d, required %0d", mag_out, exp_v);
          end
        end
      end
      if (in_valid && in_ready && n_acc < 3) begin
        sb.push_back(ref_mag(i_in, q_in));
        t_acc[n_acc] = c;
        n_acc++;
        acc_now = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc_now) begin
        if (n_acc < 3) begin
          i_in = pi[n_acc];
          q_in = pq[n_acc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    compared++;
    if (n_acc != 3 || n_out != 3) begin
      mismatched++;
      $display("FAIL b2b_count: accepts=%0d outputs=%0d, required 3/3", n_acc, n_out);
    end else begin
      compared++;
      if (t_acc[1] - t_acc[0] != PERIOD || t_acc[2] - t_acc[1] != PERIOD) begin
        mismatched++;
        $display("FAIL b2b_period: gaps %0d,%0d, required %0d", t_acc[1] - t_acc[0], t_acc[2] - t_acc[1], PERIOD);
      end
    end
  endtask

  task automatic test_random();
    logic signed [IN_W-1:0] iv, qv;
    for (int n = 0; n < 1500; n++) begin
      iv = $urandom();
      qv = $urandom();
      if ($urandom_range(0, 9) == 0) iv = -16'sd32768;
      if ($urandom_range(0, 9) == 0) qv = ($urandom_range(0, 1) == 0) ? 16'sd32767 : -16'sd32768;
      if ($urandom_range(0, 7) == 0) iv = $urandom_range(0, 15);
      run_op(iv, qv, $urandom_range(0, 3), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
